// File: rtl/vga_sprite_scheduler_if.sv
// Sprite update handshake between game logic and the scheduler.
// Master posts {sel, en, x, y, color}; slave answers with ready.
interface vga_sprite_scheduler_if;
  logic        valid;
  logic        ready;
  logic        sel;
  logic        en;
  logic [10:0] x;
  logic [10:0] y;
  logic [11:0] color;

  modport master (
    output valid,
    output sel,
    output en,
    output x,
    output y,
    output color,
    input  ready
  );

  modport slave (
    input  valid,
    input  sel,
    input  en,
    input  x,
    input  y,
    input  color,
    output ready
  );
endinterface

// File: rtl/vga_sprite_scheduler.sv
// Two-sprite overlay scheduler: shadowed updates commit at VBlank start.
// Optional collision flag built when VGA_COLLISION_EN is defined.
module vga_sprite_scheduler #(
  parameter int SPR_W = 16,
  parameter int SPR_H = 16,
  parameter int X_MAX = 800,
  parameter int Y_MAX = 600
) (
  input  logic        CLK_100MHz,
  input  logic        RESET_N,
  input  logic [10:0] CurrentX,
  input  logic [10:0] CurrentY,
  input  logic        VBlank,
  input  logic        HBlank,
  vga_sprite_scheduler_if.slave upd,
  output logic [3:0]  redOne,
  output logic [3:0]  greenOne,
  output logic [3:0]  blueOne,
  output logic [3:0]  redTwo,
  output logic [3:0]  greenTwo,
  output logic [3:0]  blueTwo,
  output logic        yesOne,
  output logic        yesTwo,
  output logic [15:0] frame_count,
  output logic        COLLIDE
);

  localparam logic [1:0] S_SCAN   = 2'd0;
  localparam logic [1:0] S_COMMIT = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;

  localparam logic [10:0] X_LIM = 11'(X_MAX - SPR_W);
  localparam logic [10:0] Y_LIM = 11'(Y_MAX - SPR_H);
  localparam logic [11:0] SW12  = 12'(SPR_W);
  localparam logic [11:0] SH12  = 12'(SPR_H);

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic              commit;

  logic [1:0]        pend_q;
  logic [1:0]        pend_d;
  logic [1:0]        sh_en_q;
  logic [1:0]        sh_en_d;
  logic [1:0][10:0]  sh_x_q;
  logic [1:0][10:0]  sh_x_d;
  logic [1:0][10:0]  sh_y_q;
  logic [1:0][10:0]  sh_y_d;
  logic [1:0][11:0]  sh_col_q;
  logic [1:0][11:0]  sh_col_d;

  logic [1:0]        act_en_q;
  logic [1:0]        act_en_d;
  logic [1:0][10:0]  act_x_q;
  logic [1:0][10:0]  act_x_d;
  logic [1:0][10:0]  act_y_q;
  logic [1:0][10:0]  act_y_d;
  logic [1:0][11:0]  act_col_q;
  logic [1:0][11:0]  act_col_d;

  logic [1:0]        hit_raw;
  logic [1:0]        yes_q;
  logic [1:0]        yes_d;
  logic [15:0]       fc_q;
  logic [15:0]       fc_d;

  logic              accept;
  logic [10:0]       x_clamp;
  logic [10:0]       y_clamp;
  logic [11:0]       px;
  logic [11:0]       py;

  assign commit    = (state_q == S_COMMIT);
  assign upd.ready = ~pend_q[upd.sel];
  assign accept    = upd.valid & upd.ready;
  assign x_clamp   = (upd.x > X_LIM) ? X_LIM : upd.x;
  assign y_clamp   = (upd.y > Y_LIM) ? Y_LIM : upd.y;
  assign px        = {1'b0, CurrentX};
  assign py        = {1'b0, CurrentY};

  // Frame FSM: one COMMIT cycle per VBlank entry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SCAN:   if (VBlank) state_d = S_COMMIT;
      S_COMMIT: state_d = S_HOLD;
      S_HOLD:   if (!VBlank) state_d = S_SCAN;
      default:  state_d = S_SCAN;
    endcase
  end

  // Shadow load on accept; pending flags drop at commit.
  always_comb begin
    sh_en_d  = sh_en_q;
    sh_x_d   = sh_x_q;
    sh_y_d   = sh_y_q;
    sh_col_d = sh_col_q;
    pend_d   = commit ? 2'b00 : pend_q;
    if (accept) begin
      sh_en_d[upd.sel]  = upd.en;
      sh_x_d[upd.sel]   = x_clamp;
      sh_y_d[upd.sel]   = y_clamp;
      sh_col_d[upd.sel] = upd.color;
      pend_d[upd.sel]   = 1'b1;
    end
  end

  // Pending shadows become active only on the commit cycle.
  always_comb begin
    act_en_d  = act_en_q;
    act_x_d   = act_x_q;
    act_y_d   = act_y_q;
    act_col_d = act_col_q;
    if (commit) begin
      for (int n = 0; n < 2; n++) begin
        if (pend_q[n]) begin
          act_en_d[n]  = sh_en_q[n];
          act_x_d[n]   = sh_x_q[n];
          act_y_d[n]   = sh_y_q[n];
          act_col_d[n] = sh_col_q[n];
        end
      end
    end
  end

  // Rectangle hit test against active sprites, 12-bit sums.
  always_comb begin
    hit_raw = 2'b00;
    for (int n = 0; n < 2; n++) begin
      hit_raw[n] = !VBlank && !HBlank && act_en_q[n]
        && (px >= {1'b0, act_x_q[n]})
        && (px <  ({1'b0, act_x_q[n]} + SW12))
        && (py >= {1'b0, act_y_q[n]})
        && (py <  ({1'b0, act_y_q[n]} + SH12));
    end
    yes_d = hit_raw;
  end

  // Frame counter steps once per commit, wrapping naturally.
  always_comb begin
    fc_d = fc_q;
    if (commit) fc_d = fc_q + 16'd1;
  end

  // Core state registers.
  always_ff @(posedge CLK_100MHz) begin
    if (!RESET_N) begin
      state_q   <= S_SCAN;
      pend_q    <= '0;
      sh_en_q   <= '0;
      sh_x_q    <= '0;
      sh_y_q    <= '0;
      sh_col_q  <= '0;
      act_en_q  <= '0;
      act_x_q   <= '0;
      act_y_q   <= '0;
      act_col_q <= '0;
      yes_q     <= '0;
      fc_q      <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      sh_en_q   <= sh_en_d;
      sh_x_q    <= sh_x_d;
      sh_y_q    <= sh_y_d;
      sh_col_q  <= sh_col_d;
      act_en_q  <= act_en_d;
      act_x_q   <= act_x_d;
      act_y_q   <= act_y_d;
      act_col_q <= act_col_d;
      yes_q     <= yes_d;
      fc_q      <= fc_d;
    end
  end

`ifdef VGA_COLLISION_EN
  logic flag_q;
  logic flag_d;
  logic collide_q;
  logic collide_d;

  // Sticky overlap flag; published and cleared at commit.
  always_comb begin
    flag_d    = flag_q | (&hit_raw);
    collide_d = collide_q;
    if (commit) begin
      collide_d = flag_q;
      flag_d    = 1'b0;
    end
  end

  // Collision registers.
  always_ff @(posedge CLK_100MHz) begin
    if (!RESET_N) begin
      flag_q    <= 1'b0;
      collide_q <= 1'b0;
    end else begin
      flag_q    <= flag_d;
      collide_q <= collide_d;
    end
  end

  assign COLLIDE = collide_q;
`else
  assign COLLIDE = 1'b0;
`endif

  assign yesOne      = yes_q[0];
  assign yesTwo      = yes_q[1];
  assign frame_count = fc_q;
  assign redOne      = act_col_q[0][11:8];
  assign greenOne    = act_col_q[0][7:4];
  assign blueOne     = act_col_q[0][3:0];
  assign redTwo      = act_col_q[1][11:8];
  assign greenTwo    = act_col_q[1][7:4];
  assign blueTwo     = act_col_q[1][3:0];

endmodule

// File: tb/tb_vga_sprite_scheduler.sv
// Bench for vga_sprite_scheduler: directed frames then random traffic,
// checked against a frame-level sprite model.
module tb_vga_sprite_scheduler;

  localparam int SW = 16;
  localparam int SH = 16;
  localparam int XM = 800;
  localparam int YM = 600;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] cx, cy;
  logic        vb, hb;
  logic [3:0]  r1, g1, b1, r2, g2, b2;
  logic        y1, y2;
  logic [15:0] fc;
  logic        col;

  vga_sprite_scheduler_if uif ();

  vga_sprite_scheduler #(
    .SPR_W(SW), .SPR_H(SH), .X_MAX(XM), .Y_MAX(YM)
  ) dut (
    .CLK_100MHz (clk),
    .RESET_N    (rst_n),
    .CurrentX   (cx),
    .CurrentY   (cy),
    .VBlank     (vb),
    .HBlank     (hb),
    .upd        (uif.slave),
    .redOne     (r1),
    .greenOne   (g1),
    .blueOne    (b1),
    .redTwo     (r2),
    .greenTwo   (g2),
    .blueTwo    (b2),
    .yesOne     (y1),
    .yesTwo     (y2),
    .frame_count(fc),
    .COLLIDE    (col)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // model: what game logic has posted and what the screen shows
  int m_act_en[2], m_act_x[2], m_act_y[2], m_act_col[2];
  int m_sh_en[2], m_sh_x[2], m_sh_y[2], m_sh_col[2];
  bit m_pend[2];
  bit m_yes[2];
  int m_fc;
  bit m_armed, m_commit_next, m_flag, m_collide, m_known;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit hit(int n, int x, int y, bit v, bit h);
    return !v && !h && (m_act_en[n] != 0)
      && x >= m_act_x[n] && x < m_act_x[n] + SW
      && y >= m_act_y[n] && y < m_act_y[n] + SH;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      m_act_en[n] = 0; m_act_x[n] = 0; m_act_y[n] = 0; m_act_col[n] = 0;
      m_sh_en[n] = 0;  m_sh_x[n] = 0;  m_sh_y[n] = 0;  m_sh_col[n] = 0;
      m_pend[n] = 0;   m_yes[n] = 0;
    end
    m_fc = 0; m_flag = 0; m_collide = 0;
    m_armed = 1; m_commit_next = 0; m_known = 1;
  endtask

  // One clock: drive, check ready, clock, advance model, check outputs.
  task automatic cyc(input bit r_n, input bit v_b, input bit h_b,
                     input int x, input int y,
                     input bit val, input bit s, input bit e,
                     input int ux, input int uy, input int c,
                     output bit acc);
    bit commit_now, h0, h1;
    bit was[2];
    int ex;
    @(negedge clk);
    rst_n = r_n; vb = v_b; hb = h_b;
    cx = 11'(x); cy = 11'(y);
    uif.valid = val; uif.sel = s; uif.en = e;
    uif.x = 11'(ux); uif.y = 11'(uy); uif.color = 12'(c);
    #1;
    if (m_known) chk("upd_ready", uif.ready, !m_pend[s]);
    @(posedge clk);
    acc = 0;
    if (!r_n) begin
      model_reset();
    end else begin
      commit_now = m_commit_next;
      h0 = hit(0, x, y, v_b, h_b);
      h1 = hit(1, x, y, v_b, h_b);
      m_yes[0] = h0; m_yes[1] = h1;
      was = m_pend;
      if (commit_now) begin
        for (int n = 0; n < 2; n++)
          if (was[n]) begin
            m_act_en[n] = m_sh_en[n]; m_act_x[n] = m_sh_x[n];
            m_act_y[n] = m_sh_y[n];   m_act_col[n] = m_sh_col[n];
            m_pend[n] = 0;
          end
        m_fc = (m_fc + 1) % 65536;
        m_collide = m_flag;
        m_flag = 0;
      end else if (h0 && h1) begin
        m_flag = 1;
      end
      if (val && !was[s]) begin
        m_sh_en[s] = e;
        m_sh_x[s] = (ux > XM - SW) ? XM - SW : ux;
        m_sh_y[s] = (uy > YM - SH) ? YM - SH : uy;
        m_sh_col[s] = c;
        m_pend[s] = 1;
        acc = 1;
      end
      m_commit_next = m_armed && v_b;
      if (m_commit_next) m_armed = 0;
      else if (!commit_now && !v_b) m_armed = 1;
    end
    #1;
    chk("yesOne", y1, m_yes[0]);
    chk("yesTwo", y2, m_yes[1]);
    chk("frame_count", fc, m_fc);
    ex = m_act_col[0];
    chk("colorOne", {r1, g1, b1}, ex);
    ex = m_act_col[1];
    chk("colorTwo", {r2, g2, b2}, ex);
`ifdef VGA_COLLISION_EN
    chk("COLLIDE", col, m_collide);
`else
    chk("COLLIDE", col, 0);
`endif
  endtask

  task automatic idle(bit v, int x, int y);
    bit a;
    cyc(1, v, 0, x, y, 0, 0, 0, 0, 0, 0, a);
  endtask

  // Hold an update until the model says it is taken (bounded).
  task automatic post(bit s, bit e, int ux, int uy, int c, bit v,
                      int x, int y);
    bit a = 0;
    for (int i = 0; i < 40 && !a; i++)
      cyc(1, v, 0, x, y, 1, s, e, ux, uy, c, a);
    if (!a) begin
      errors++;
      $display("FAIL post_timeout observed=no_accept expected=accept");
    end
  endtask

  task automatic vblank(int n);
    for (int i = 0; i < n; i++) idle(1, 0, 0);
  endtask

  initial begin
    bit a;
    int xs[4];
    int ys[4];
    int v, rx, ry, n;
    m_known = 0;
    m_armed = 1;
    m_commit_next = 0;
    rst_n = 0; vb = 1; hb = 0; cx = 0; cy = 0;
    uif.valid = 0; uif.sel = 0; uif.en = 0;
    uif.x = 0; uif.y = 0; uif.color = 0;

    // reset with VBlank high, then the post-reset commit
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, a);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, a);
    idle(1, 0, 0);
    idle(1, 0, 0);
    chk("fc_after_reset", fc, 1);
    chk("ready_after_reset", uif.ready, 1);
    for (int i = 0; i < 3; i++) idle(0, i, 0);

    // sprite 0 posted mid-frame must not show this frame
    post(0, 1, 100, 50, 'hF00, 0, 100, 50);
    idle(0, 100, 50);
    idle(0, 107, 58);
    chk("yesOne_pre_commit", y1, 0);
    vblank(3);
    chk("redOne_commit", r1, 4'hF);
    xs = '{99, 100, 115, 116};
    ys = '{49, 50, 65, 66};
    foreach (ys[j]) foreach (xs[i]) idle(0, xs[i], ys[j]);
    idle(0, 110, 60);
    chk("yesOne_inside", y1, 1);
    cyc(1, 0, 1, 110, 60, 0, 0, 0, 0, 0, 0, a);

    // two updates to sprite 1 in one frame
    post(1, 1, 300, 200, 'h0F0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      cyc(1, 0, 0, 0, 0, 1, 1, 1, 400, 300, 'h00F, a);
    chk("second_update_stalled", uif.ready, 0);
    post(1, 1, 400, 300, 'h00F, 1, 0, 0);
    vblank(2);
    idle(0, 305, 205);
    idle(0, 405, 305);
    vblank(3);
    idle(0, 405, 305);
    chk("yesTwo_second", y2, 1);

    // accept on the commit cycle, plus clamping of x and y
    idle(0, 0, 0);
    idle(1, 0, 0);
    cyc(1, 1, 0, 0, 0, 1, 0, 1, 795, 590, 'h0AB, a);
    vblank(2);
    idle(0, 105, 55);
    chk("commit_cycle_update_deferred", y1, 1);
    idle(0, 790, 590);
    vblank(3);
    foreach (xs[i]) xs[i] = 782 + i * 2;
    idle(0, 783, 584);
    idle(0, 784, 584);
    idle(0, 799, 599);
    idle(0, 800, 599);
    idle(0, 790, 583);

    // overlapping sprites for collision
    post(1, 1, 790, 590, 'hABC, 0, 0, 0);
    vblank(3);
    idle(0, 790, 590);
    post(1, 0, 10, 10, 'h123, 0, 0, 0);
    vblank(3);
    idle(0, 790, 590);
    vblank(3);
    idle(0, 5, 5);

    // random traffic with occasional reset
    v = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 24) == 0) v = !v;
      n = $urandom_range(0, 1);
      rx = m_act_x[n] + $urandom_range(0, 20) - 2;
      ry = m_act_y[n] + $urandom_range(0, 20) - 2;
      if (rx < 0) rx = 0;
      if (ry < 0) ry = 0;
      cyc(($urandom_range(0, 599) != 0), v[0],
          ($urandom_range(0, 7) == 0), rx, ry,
          ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 3) != 0),
          $urandom_range(0, 820), $urandom_range(0, 620),
          $urandom_range(0, 4095), a);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_sprite_scheduler.md
# vga_sprite_scheduler

Frame-synchronous sprite controller feeding the VGA color client's two overlay inputs (one-set and two-set color/hit signals). Game logic posts sprite position, color and enable updates through a valid/ready handshake. Updates are held in per-sprite shadow registers and committed atomically at the start of vertical blanking, so a sprite never tears mid-frame. Per pixel, the block compares the scan position against each active sprite rectangle and drives registered hit flags and colors into the client.

## Interface
- SPR_W, 16, sprite width in pixels (1..X_MAX)
- SPR_H, 16, sprite height in pixels (1..Y_MAX)
- X_MAX, 800, visible width
- Y_MAX, 600, visible height

- CLK_100MHz  in  1  system clock; all logic on rising edge
- RESET_N  in  1  reset, synchronous, active-low
- CurrentX, CurrentY  in  11  scan position from timing generator
- VBlank, HBlank  in  1  blanking flags
- upd_valid  in  1  update request
- upd_ready  out  1  update accepted when valid & ready
- upd_sel  in  1  target sprite (0 = One, 1 = Two)
- upd_en  in  1  sprite enable after commit
- upd_x, upd_y  in  11  sprite top-left corner
- upd_color  in  12  {R,G,B} 4 bits each
- redOne, greenOne, blueOne, redTwo, greenTwo, blueTwo  out  4  committed sprite colors
- yesOne, yesTwo  out  1  registered pixel-hit flags
- frame_count  out  16  commit counter
- COLLIDE  out  1  previous-frame collision flag (see Configuration)

## Operation
- Frame FSM states:
  - SCAN: VBlank=0. Moves to COMMIT on the first cycle VBlank=1.
  - COMMIT: lasts exactly 1 cycle, then HOLD.
  - HOLD: stays while VBlank=1; moves to SCAN on VBlank=0.
  - Reset state is SCAN.
- Shadow per sprite: {en, x, y, color} plus pend flag.
  - upd_ready = !pend[upd_sel], combinational.
  - On accept: shadow[upd_sel] loads, pend[upd_sel] set.
  - A second update to a pending sprite stalls until the next commit.
- COMMIT cycle:
  - Every sprite with pend=1 copies shadow to active; its pend clears.
  - Sprites with pend=0 keep their active values.
  - frame_count increments, wrapping 0xFFFF to 0x0000.
- Same-cycle accept and COMMIT: pend was 0 before the cycle, so the new update lands in shadow with pend=1 and commits at the next frame, not this one.
- Clamping, applied at accept:
  - x > X_MAX-SPR_W stores X_MAX-SPR_W.
  - y > Y_MAX-SPR_H stores Y_MAX-SPR_H.
- Hit test for sprite N: !VBlank & !HBlank & en_N & X>=x_N & X<x_N+SPR_W & Y>=y_N & Y<y_N+SPR_H.
  - Sums use 12-bit width; no overflow.
- Colors are driven from active registers and change only on COMMIT.
- Priority between sprites is resolved by the client (One over Two); this block drives both hits independently.

## Timing
- Reset values:
  - yesOne, yesTwo, frame_count, COLLIDE, all color outputs = 0.
  - Active en = 0, positions 0, pend = 0.
  - upd_ready = 1 after reset.
- Hit latency: yesN reflects CurrentX/CurrentY/blanking sampled one cycle earlier.
- Commit occurs one cycle after the VBlank rising edge is sampled, so new sprite state is visible from the next active line.
- Reset with VBlank high: FSM leaves SCAN for COMMIT on the first post-reset cycle (frame_count becomes 1, nothing pending).
- Reset asserted mid-frame or mid-handshake discards all shadow and active state.

## Configuration
- VGA_COLLISION_EN defined:
  - A sticky flag sets on any cycle where both raw hits are true.
  - At COMMIT, COLLIDE loads the flag and the flag clears; COLLIDE is held for the following frame.
- VGA_COLLISION_EN undefined: no collision logic is built; COLLIDE is tied 0.

## Test plan
- Reset, VBlank high → frame_count=1 after 2 cycles; yesOne=yesTwo=0; upd_ready=1.
- Post sprite 0 {en=1, x=100, y=50, color=0xF00} mid-frame → yesOne stays 0 this frame. After next VBlank: redOne=0xF, yesOne=1 exactly at X∈[100,115], Y∈[50,65], one cycle after the position is presented.
- Post two updates to sprite 1 in one frame → second sees upd_ready=0 until the COMMIT cycle, then is accepted and commits one frame later.
- Accept on the COMMIT cycle → that update is not committed until the following VBlank.
- upd_x=795 → stored x=784; hit spans X 784..799.
- Overlapping sprites with VGA_COLLISION_EN defined → COLLIDE=1 for the next frame only. Without the macro → COLLIDE=0.
